counter_scheduler: RTL and testbench

- Shares one CNT_W-bit up-counter among N_REQ requesters.
- Each requester asks for a timed run of (tc+1) cycles.
- A round-robin arbiter picks one owner and the block sequences the counter from 0 to that owner's terminal count. It then pulses done to the owner and releases the counter.
- Sits between requesting control blocks and the shared counter datapath.

---
 rtl/counter_scheduler_pkg.sv | 17 +
 rtl/counter_scheduler_cnt_core.sv | 62 ++++++
 rtl/counter_scheduler.sv | 140 ++++++++++++++
 tb/tb_counter_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_scheduler_pkg.sv
// Shared definitions for the counter scheduler: FSM state encoding and default sizes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package counter_scheduler_pkg;

  // Default sizing; IDX_W_DEF must stay equal to ceil(log2(N_REQ_DEF)).
  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 3;
  localparam int IDX_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_scheduler_cnt_core.sv
// Shared CNT_W-bit up-counter with clear, increment and terminal-count compare.
// Latency: count updates one cycle after clr/inc; at_tc is combinational on the registered count.
// Backpressure: none; the scheduler FSM owns clr/inc every cycle.
//
// Ports (dff):
//   clk, rst (sync, active-low), en (load enable), d -> q (registered)
// Ports (sched_cnt_core):
//   clk, rst    clock and sync active-low reset
//   clr         load 0 on the next edge (wins over inc)
//   inc         count up by one on the next edge
//   tc_lat      latched terminal count of the current owner
//   cnt         registered count value
//   at_tc       cnt == tc_lat

module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module sched_cnt_core #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] tc_lat,
  output logic [CNT_W-1:0] cnt,
  output logic             at_tc
);

  logic [CNT_W-1:0] cnt_d;

  // The scheduler clears on the terminal cycle, so the increment can never wrap.
  assign cnt_d = clr ? '0 : cnt + CNT_W'(1);

  dff #(.W(CNT_W)) u_cnt_reg (
    .clk (clk),
    .rst (rst),
    .en  (clr | inc),
    .d   (cnt_d),
    .q   (cnt)
  );

  assign at_tc = (cnt == tc_lat);

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one up-counter among N_REQ requesters; each job counts 0..tc, then pulses done.
// Latency: req sampled in cycle t -> gnt in t+1; gnt lasts tc+1 cycles, done one cycle, then one idle arbitration cycle.
// Backpressure: requesters hold req until done (dropping it aborts the job); done is a one-cycle pulse with no handshake.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-low reset
//   req      per-requester request level
//   tc       per-requester terminal count, slice i = tc[i*CNT_W +: CNT_W]
//   gnt      one-hot grant, high for the whole RUN phase
//   done     one-hot single-cycle completion pulse
//   busy     state != IDLE
//   cnt_out  shared count, 0 outside RUN
//   owner    index of current or most recent owner

module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] tc,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt_out,
  output logic [IDX_W-1:0]       owner
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] tc_lat;
  logic [IDX_W-1:0] win;
  logic [CNT_W-1:0] tc_win;
  logic             owner_req;
  logic             at_tc;
  logic             run_step;

  // First set request scanning ptr, ptr+1, ... modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] idx;
    logic             hit;
    w   = p;
    hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IDX_W'((int'(p) + i) % N_REQ);
      if (!hit && r[idx]) begin
        hit = 1'b1;
        w   = idx;
      end
    end
    return w;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] o);
    return (o == IDX_W'(N_REQ - 1)) ? '0 : o + IDX_W'(1);
  endfunction

  assign win = rr_pick(req, ptr);

  always_comb begin
    tc_win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        tc_win = tc[i*CNT_W +: CNT_W];
      end
    end
  end

  assign owner_req = req[owner];

  // Count only while running with the owner still requesting and short of its
  // terminal count; every other cycle parks the counter at zero.
  assign run_step = (state == RUN) && owner_req && !at_tc;

  sched_cnt_core #(.CNT_W(CNT_W)) u_cnt_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (!run_step),
    .inc    (run_step),
    .tc_lat (tc_lat),
    .cnt    (cnt_out),
    .at_tc  (at_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      owner  <= '0;
      ptr    <= '0;
      tc_lat <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= RUN;
            gnt    <= N_REQ'(1) << win;
            owner  <= win;
            tc_lat <= tc_win;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          // Abort is checked first so a drop on the terminal cycle gives no done.
          if (!owner_req) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= next_idx(owner);
          end else if (at_tc) begin
            state <= DONE;
            gnt   <= '0;
            done  <= gnt;
            ptr   <= next_idx(owner);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed self-checking bench for counter_scheduler (N_REQ=4, CNT_W=3).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each scenario task holds a table of hand-computed expected output vectors.
module tb_counter_scheduler;

  localparam int N_REQ = 4;
  localparam int CNT_W = 3;
  localparam int IDX_W = 2;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic [2:0] cnt;
    logic [1:0] owner;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] tc  = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [2:0]  cnt_out;
  logic [1:0]  owner;
  obs_t        obs;

  int vec_cnt = 0;
  int err_cnt = 0;

  counter_scheduler #(.N_REQ(N_REQ), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .tc      (tc),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .cnt_out (cnt_out),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  assign obs = {gnt, done, busy, cnt_out, owner};

  function automatic obs_t ev(input logic [3:0] g, input logic [3:0] d, input logic b,
                              input logic [2:0] c, input logic [1:0] o);
    return {g, d, b, c, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t tab[$];
    obs_t e;
    rst = 1'b0;
    req = 4'b1111;
    tc  = '0;
    tab.push_back(ev(4'b0000, 4'b0000, 1'b0, 3'd0, 2'd0));
    tab.push_back(ev(4'b0000, 4'b0000, 1'b0, 3'd0, 2'd0));
    tab.push_back(ev(4'b0001, 4'b0000, 1'b1, 3'd0, 2'd0));
    tab.push_back(ev(4'b0000, 4'b0001, 1'b1, 3'd0, 2'd0));
    tab.push_back(ev(4'b0000, 4'b0000, 1'b0, 3'd0, 2'd0));
    for (int k = 0; k < tab.size(); k++) begin
      tick();
      e = tab[k];
      vec_cnt++;
      if (obs !== e) begin
        err_cnt++;
        $display("FAIL reset[%0d]: got gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d, expected gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d",
                 k, obs.gnt, obs.done, obs.busy, obs.cnt, obs.owner, e.gnt, e.done, e.busy, e.cnt, e.owner);
      end
      if (k == 1) rst = 1'b1;
      if (k == 2) req = 4'b0001;
      if (k == 3) req = 4'b0000;
    end
  endtask

  task automatic test_single_job();
    obs_t tab[$];
    obs_t e;
    do_reset();
    req = 4'b0100;
    tc  = 12'(3) << 6;
    for (int c = 0; c < 4; c++) tab.push_back(ev(4'b0100, 4'b0000, 1'b1, 3'(c), 2'd2));
    tab.push_back(ev(4'b0000, 4'b0100, 1'b1, 3'd0, 2'd2));
    tab.push_back(ev(4'b0000, 4'b0000, 1'b0, 3'd0, 2'd2));
    for (int k = 0; k < tab.size(); k++) begin
      tick();
      e = tab[k];
      vec_cnt++;
      if (obs !== e) begin
        err_cnt++;
        $display("FAIL single_job[%0d]: got gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d, expected gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d",
                 k, obs.gnt, obs.done, obs.busy, obs.cnt, obs.owner, e.gnt, e.done, e.busy, e.cnt, e.owner);
      end
      if (k == 4) req = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    obs_t tab[$];
    obs_t e;
    logic [3:0] oh;
    int done_pulses;
    done_pulses = 0;
    do_reset();
    req = 4'b1111;
    tc  = '0;
    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << (j % 4);
      tab.push_back(ev(oh, 4'b0000, 1'b1, 3'd0, 2'(j % 4)));
      tab.push_back(ev(4'b0000, oh, 1'b1, 3'd0, 2'(j % 4)));
      tab.push_back(ev(4'b0000, 4'b0000, 1'b0, 3'd0, 2'(j % 4)));
    end
    for (int k = 0; k < tab.size(); k++) begin
      tick();
      e = tab[k];
      done_pulses += $countones(done);
      vec_cnt++;
      if (obs !== e) begin
        err_cnt++;
        $display("FAIL round_robin[%0d]: got gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d, expected gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d",
                 k, obs.gnt, obs.done, obs.busy, obs.cnt, obs.owner, e.gnt, e.done, e.busy, e.cnt, e.owner);
      end
    end
    req = 4'b0000;
    vec_cnt++;
    if (done_pulses !== 5) begin
      err_cnt++;
      $display("FAIL round_robin_done_count: got %0d pulses, expected 5", done_pulses);
    end
  endtask

  task automatic test_boundary();
    obs_t tab[$];
    obs_t e;
    do_reset();
    req = 4'b0001;
    tc  = 12'd7;
    for (int c = 0; c < 8; c++) tab.push_back(ev(4'b0001, 4'b0000, 1'b1, 3'(c), 2'd0));
    tab.push_back(ev(4'b0000, 4'b0001, 1'b1, 3'd0, 2'd0));
    tab.push_back(ev(4'b0000, 4'b0000, 1'b0, 3'd0, 2'd0));
    for (int k = 0; k < tab.size(); k++) begin
      tick();
      e = tab[k];
      vec_cnt++;
      if (obs !== e) begin
        err_cnt++;
        $display("FAIL boundary[%0d]: got gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d, expected gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d",
                 k, obs.gnt, obs.done, obs.busy, obs.cnt, obs.owner, e.gnt, e.done, e.busy, e.cnt, e.owner);
      end
      // The latched terminal count must survive a tc change mid-run.
      if (k == 0) tc = 12'd2;
      if (k == 8) req = 4'b0000;
    end
  endtask

  task automatic test_abort();
    obs_t tab[$];
    obs_t e;
    do_reset();
    req = 4'b0110;
    tc  = 12'(5) << 3;
    tab.push_back(ev(4'b0010, 4'b0000, 1'b1, 3'd0, 2'd1));
    tab.push_back(ev(4'b0010, 4'b0000, 1'b1, 3'd1, 2'd1));
    tab.push_back(ev(4'b0010, 4'b0000, 1'b1, 3'd2, 2'd1));
    tab.push_back(ev(4'b0000, 4'b0000, 1'b0, 3'd0, 2'd1));
    tab.push_back(ev(4'b0100, 4'b0000, 1'b1, 3'd0, 2'd2));
    tab.push_back(ev(4'b0000, 4'b0100, 1'b1, 3'd0, 2'd2));
    tab.push_back(ev(4'b0000, 4'b0000, 1'b0, 3'd0, 2'd2));
    for (int k = 0; k < tab.size(); k++) begin
      tick();
      e = tab[k];
      vec_cnt++;
      if (obs !== e) begin
        err_cnt++;
        $display("FAIL abort[%0d]: got gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d, expected gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d",
                 k, obs.gnt, obs.done, obs.busy, obs.cnt, obs.owner, e.gnt, e.done, e.busy, e.cnt, e.owner);
      end
      if (k == 2) req = 4'b0100;
      if (k == 5) req = 4'b0000;
    end
  endtask

  // Runs straight after test_abort without a reset, so the pointer starts at 3.
  task automatic test_reset_mid_run();
    obs_t tab[$];
    obs_t e;
    req = 4'b0100;
    tc  = 12'(6) << 6;
    for (int c = 0; c < 5; c++) tab.push_back(ev(4'b0100, 4'b0000, 1'b1, 3'(c), 2'd2));
    tab.push_back(ev(4'b0000, 4'b0000, 1'b0, 3'd0, 2'd0));
    tab.push_back(ev(4'b0010, 4'b0000, 1'b1, 3'd0, 2'd1));
    tab.push_back(ev(4'b0000, 4'b0010, 1'b1, 3'd0, 2'd1));
    tab.push_back(ev(4'b0000, 4'b0000, 1'b0, 3'd0, 2'd1));
    for (int k = 0; k < tab.size(); k++) begin
      tick();
      e = tab[k];
      vec_cnt++;
      if (obs !== e) begin
        err_cnt++;
        $display("FAIL reset_mid_run[%0d]: got gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d, expected gnt=%b done=%b busy=%b cnt_out=%0d owner=%0d",
                 k, obs.gnt, obs.done, obs.busy, obs.cnt, obs.owner, e.gnt, e.done, e.busy, e.cnt, e.owner);
      end
      if (k == 4) rst = 1'b0;
      if (k == 5) begin
        rst = 1'b1;
        req = 4'b1010;
      end
      if (k == 6) req = 4'b0010;
      if (k == 7) req = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_boundary();
    test_abort();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
